// File: rtl/shiftin_74lv165_ctrl.sv
// shiftin_74lv165_ctrl
// Serial-in reader for CH independent daisy-chained 74LV165 PISO chains.
// Each frame: parallel load (SH_LDn low for 2 ticks), then BITS samples of QH,
// each taken at the end of an RCLK-low tick, with an RCLK-high tick between
// consecutive samples. The frame is then published on data_o with a valid strobe.
//
// Ports:
//   clk, resetn  - system clock, asynchronous active-low reset
//   start        - frame request (CONTINUOUS=0 only, sampled in IDLE)
//   busy         - high whenever the FSM is not idle
//   data_o       - last complete frame, channel c at [c*BITS +: BITS], MSB first on wire
//   valid        - 1-cycle pulse when data_o updates
//   changed      - 1-cycle pulse with valid when the new frame differs from the old one
//   frame_cnt    - completed-frame count, wraps
//   SH_LDn, RCLK - registered controls to the 74LV165 chains
//   QH           - serial data, one bit per chain
module shiftin_74lv165_ctrl #(
  parameter int unsigned CH         = 4,
  parameter int unsigned BITS       = 16,
  parameter int unsigned DIV        = 1,
  parameter int unsigned CONTINUOUS = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  output logic                 busy,
  output logic [CH*BITS-1:0]   data_o,
  output logic                 valid,
  output logic                 changed,
  output logic [7:0]           frame_cnt,
  output logic                 SH_LDn,
  output logic                 RCLK,
  input  logic [CH-1:0]        QH
);

  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BitW = $clog2(BITS);
  localparam logic [DivW-1:0] DivMax = DivW'(DIV - 1);
  localparam logic [DivW-1:0] DivOne = DivW'(1);
  localparam logic [BitW-1:0] BitMax = BitW'(BITS - 1);
  localparam logic [BitW-1:0] BitOne = BitW'(1);
  localparam bit Cont = (CONTINUOUS != 0);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StShift = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [DivW-1:0]    div_cnt_q, div_cnt_d;
  logic               ld_tick_q, ld_tick_d;   // first LOAD tick already elapsed
  logic               phase_q, phase_d;       // 0 = RCLK-low tick, 1 = RCLK-high tick
  logic [BitW-1:0]    bit_idx_q, bit_idx_d;
  logic [CH*BITS-1:0] sr_q, sr_d;
  logic [CH*BITS-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               changed_q, changed_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic               sh_ldn_q, sh_ldn_d;
  logic               rclk_q, rclk_d;

  logic               tick;
  logic [CH*BITS-1:0] sr_shift;

  assign tick = (div_cnt_q == DivMax);

  // Every chain shifts left, taking its QH into the LSB.
  always_comb begin
    sr_shift = '0;
    for (int c = 0; c < int'(CH); c++) begin
      sr_shift[c*BITS +: BITS] = {sr_q[c*BITS +: BITS-1], QH[c]};
    end
  end

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    ld_tick_d   = ld_tick_q;
    phase_d     = phase_q;
    bit_idx_d   = bit_idx_q;
    sr_d        = sr_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    changed_d   = 1'b0;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      StIdle: begin
        if (Cont || start) begin
          state_d   = StLoad;
          div_cnt_d = '0;
          ld_tick_d = 1'b0;
        end
      end
      StLoad: begin
        div_cnt_d = tick ? '0 : div_cnt_q + DivOne;
        if (tick) begin
          if (ld_tick_q) begin
            state_d   = StShift;
            phase_d   = 1'b0;
            bit_idx_d = '0;
          end else begin
            ld_tick_d = 1'b1;
          end
        end
      end
      StShift: begin
        div_cnt_d = tick ? '0 : div_cnt_q + DivOne;
        if (tick) begin
          if (!phase_q) begin
            sr_d = sr_shift;
            if (bit_idx_q == BitMax) begin
              // Publish on the same edge as the last sample so valid/data_o
              // appear together during DONE.
              state_d     = StDone;
              data_d      = sr_shift;
              valid_d     = 1'b1;
              changed_d   = (sr_shift != data_q);
              frame_cnt_d = frame_cnt_q + 8'd1;
            end else begin
              phase_d = 1'b1;
            end
          end else begin
            phase_d   = 1'b0;
            bit_idx_d = bit_idx_q + BitOne;
          end
        end
      end
      StDone: begin
        if (Cont) begin
          state_d   = StLoad;
          div_cnt_d = '0;
          ld_tick_d = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Pin levels follow the next state so they are driven straight from flops.
    sh_ldn_d = (state_d != StLoad);
    rclk_d   = (state_d == StShift) && phase_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      div_cnt_q   <= '0;
      ld_tick_q   <= 1'b0;
      phase_q     <= 1'b0;
      bit_idx_q   <= '0;
      sr_q        <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      changed_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
      sh_ldn_q    <= 1'b1;
      rclk_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      ld_tick_q   <= ld_tick_d;
      phase_q     <= phase_d;
      bit_idx_q   <= bit_idx_d;
      sr_q        <= sr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      changed_q   <= changed_d;
      frame_cnt_q <= frame_cnt_d;
      sh_ldn_q    <= sh_ldn_d;
      rclk_q      <= rclk_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign data_o    = data_q;
  assign valid     = valid_q;
  assign changed   = changed_q;
  assign frame_cnt = frame_cnt_q;
  assign SH_LDn    = sh_ldn_q;
  assign RCLK      = rclk_q;

endmodule

// File: doc/shiftin_74lv165_ctrl.md
Name: shiftin_74lv165_ctrl

Overview:
- Parametrised serial-in reader for daisy-chained 74LV165 parallel-in/serial-out shift registers; successor to the fixed 4x16 board-input driver.
- Generalised in channel count, bits per chain and serial clock rate.
- Adds an on-demand start/busy handshake as an alternative to free-running scan, a frame-valid strobe, a change-detect strobe and a frame counter.
- Sits in the SoC between board switch/button chains and the MMIO register block.

Parameters:
CH, 4, number of independent 74LV165 chains, each with its own QH input; legal CH>=1.
BITS, 16, bits per chain (8 x chips in chain); legal BITS>=2.
DIV, 1, clk cycles per serial half-period (tick); legal DIV>=1.
CONTINUOUS, 1, 1 = free-running back-to-back frames; 0 = one frame per start request.

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
start  input  1  frame request; used only when CONTINUOUS=0; sampled only in IDLE
busy  output  1  high whenever state != IDLE
data_o  output  CH*BITS  last complete frame; channel c at [c*BITS +: BITS]; bit BITS-1 = first serial bit
valid  output  1  1-cycle pulse when data_o updates
changed  output  1  1-cycle pulse, coincident with valid, when new frame != previous data_o
frame_cnt  output  8  completed-frame count; wraps 255->0
SH_LDn  output  1  to 74LV165 SH/LD#; low = parallel load
RCLK  output  1  to 74LV165 CLK
QH  input  CH  serial outputs, one per chain

Behaviour:
- Reset: asynchronous on resetn low; applies mid-frame without completing it. All outputs take reset values immediately: data_o=0, valid=0, changed=0, frame_cnt=0, SH_LDn=1, RCLK=0, busy=0, state=IDLE. Partial shift data is discarded.
- Tick generator: div_cnt counts 0..DIV-1; tick when div_cnt==DIV-1. div_cnt clears on entry to LOAD.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - CONTINUOUS=1: unconditional move to LOAD on the first clk edge after reset release.
  - CONTINUOUS=0: start=1 moves to LOAD next cycle; start=0 holds IDLE.
- LOAD: SH_LDn=0, RCLK=0 for 2 ticks (2*DIV cycles). Then SH_LDn=1, bit index=0, go SHIFT.
- SHIFT, per bit i=0..BITS-1:
  - Low phase: RCLK=0 for 1 tick. On the clk edge ending the tick, each channel's shift reg shifts left with QH[c] into its LSB.
  - High phase (i<BITS-1 only): RCLK=1 for 1 tick.
  - After the BITS-th sample: RCLK stays low, go DONE. Total rising RCLK edges per frame = BITS-1.
- DONE, 1 cycle; next state is LOAD if CONTINUOUS=1, else IDLE:
  - data_o <= shift regs; valid=1.
  - changed=1 iff new value != old data_o. The first frame after reset compares against 0.
  - frame_cnt <= frame_cnt+1.
- Frame length: (2*BITS+1)*DIV+1 clk cycles; 34 cycles for BITS=16, DIV=1.
- start while busy is ignored, not queued. start is ignored entirely when CONTINUOUS=1.
- busy=1 in LOAD, SHIFT and DONE; falls in the cycle after DONE when CONTINUOUS=0.
- SH_LDn and RCLK are registered outputs (glitch-free). SH_LDn and RCLK are never both active (SH_LDn=0 and RCLK=1) in the same cycle.
- data_o holds between frames; it changes only in DONE.

Test Plan:
1. Defaults, chain model preloaded ch0=16'hA5C3, ch1=16'h0001, ch2=16'h8000, ch3=16'hFFFF -> first valid at cycle 34 after reset release; data_o={FFFF,8000,0001,A5C3}; changed=1; frame_cnt=1; 15 RCLK rises per frame.
2. Same inputs held for three frames -> valid every 34 cycles; changed=0 on frames 2 and 3. Then flip ch1 bit 0 -> next frame changed=1, data_o[31:16]=16'h0000.
3. CONTINUOUS=0, DIV=3, BITS=8, CH=1, input 8'h5A -> busy=0 until start; one start -> busy 1 for 52 cycles; valid once; data_o=8'h5A. start pulses during busy produce no extra frame.
4. resetn low during SHIFT at bit 7 -> outputs take reset values asynchronously, with no clk edge needed; no valid; after release, the first full frame completes normally with frame_cnt=1.
5. 256 frames -> frame_cnt wraps to 0 on the 256th valid.
6. Protocol check every cycle -> SH_LDn low exactly 2*DIV cycles per frame; SH_LDn=0 with RCLK=1 never occurs; QH is sampled only at the end of RCLK-low ticks.
